uart_rx_frame: RTL

- 8N1 UART receiver, LSB first. It is the receive side of the RS-232 link, and its peer transmitter uses the same frame format.
- Synchronises the asynchronous rs232_rx line and generates its own mid-bit sample timing from clk.
- Delivers each received byte with a one-cycle valid strobe and a level busy flag (rx_int), so a transmitter can loop the byte back using rx_int edge detection.
- Reports stop-bit framing errors.

---
 rtl/uart_rx_frame_if.sv | 25 ++
 rtl/uart_rx_frame.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_if.sv
// Signal bundle for the 8N1 UART receive side: serial line in, byte/strobe/status out.
// The slave end is the receiver; the master end drives the line and consumes results.
interface uart_rx_frame_if;
  logic       rs232_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_int;

  modport master (
    output rs232_rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  rx_int
  );

  modport slave (
    input  rs232_rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output rx_int
  );
endinterface

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver, LSB first: synchronises the line, samples mid-bit from its own
// baud counter, and reports each byte with a valid strobe or a stop-bit framing error.
module uart_rx_frame #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int BPS_CNT  = CLK_FREQ / BAUD,
  parameter int HALF_CNT = BPS_CNT / 2
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_frame_if.slave  bus
);

  localparam int                CNT_W     = $clog2(BPS_CNT);
  localparam logic [CNT_W-1:0]  BPS_LAST  = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_CNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchroniser flops reset high so leaving reset never looks like a start edge.
  logic [1:0] sync_reg;
  logic       rx_s_d_reg;
  logic       rx_s;
  logic       fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg   <= 2'b11;
      rx_s_d_reg <= 1'b1;
    end else begin
      sync_reg   <= {sync_reg[0], bus.rs232_rx};
      rx_s_d_reg <= sync_reg[1];
    end
  end

  assign rx_s = sync_reg[1];
  assign fall = rx_s_d_reg & ~rx_s;

  state_t           state_reg,      state_next;
  logic [CNT_W-1:0] baud_cnt_reg,   baud_cnt_next;
  logic [2:0]       bit_idx_reg,    bit_idx_next;
  logic [7:0]       shift_data_reg, shift_data_next;
  logic [7:0]       rx_data_reg,    rx_data_next;
  logic             rx_valid_reg,   rx_valid_next;
  logic             frame_err_reg,  frame_err_next;
  logic             rx_int_reg,     rx_int_next;

  logic [CNT_W-1:0] cnt_last;
  logic             sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      baud_cnt_reg   <= '0;
      bit_idx_reg    <= 3'd0;
      shift_data_reg <= 8'h00;
      rx_data_reg    <= 8'h00;
      rx_valid_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      rx_int_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      baud_cnt_reg   <= baud_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_data_reg <= shift_data_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      frame_err_reg  <= frame_err_next;
      rx_int_reg     <= rx_int_next;
    end
  end

  // Half-bit wait in START lands every later sample in the middle of its bit.
  assign cnt_last = (state_reg == START) ? HALF_LAST : BPS_LAST;
  assign sample   = (state_reg != IDLE) && (baud_cnt_reg == cnt_last);

  always_comb begin
    state_next      = state_reg;
    bit_idx_next    = bit_idx_reg;
    shift_data_next = shift_data_reg;
    rx_data_next    = rx_data_reg;
    rx_valid_next   = 1'b0;
    frame_err_next  = 1'b0;
    rx_int_next     = rx_int_reg;
    baud_cnt_next   = (state_reg == IDLE || sample) ? '0 : baud_cnt_reg + CNT_W'(1);

    case (state_reg)
      IDLE: begin
        if (fall) begin
          state_next  = START;
          rx_int_next = 1'b1;
        end
      end

      START: begin
        if (sample) begin
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
          end else begin
            state_next  = IDLE;
            rx_int_next = 1'b0;
          end
        end
      end

      DATA: begin
        if (sample) begin
          shift_data_next[bit_idx_reg] = rx_s;
          bit_idx_next                 = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end
      end

      STOP: begin
        // A low stop bit keeps the previous byte; only good frames update rx_data.
        if (sample) begin
          if (rx_s) begin
            rx_data_next  = shift_data_reg;
            rx_valid_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
          rx_int_next = 1'b0;
          state_next  = IDLE;
        end
      end

      default: begin
        state_next  = IDLE;
        rx_int_next = 1'b0;
      end
    endcase
  end

  assign bus.rx_data   = rx_data_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.rx_int    = rx_int_reg;

endmodule
